// File: rtl/id_imm_gen_pipe.sv
// Two-entry FIFO: holds up to two entries and releases them in the order they arrived.
// Latency: a pushed entry is visible on rd_vld one cycle later; a simultaneous push and pop are both accepted.
// Backpressure: wr_rdy depends only on the stored count; flush empties the FIFO and masks that cycle's push and pop.
module sync_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    logic [W-1:0] mem [2];
    logic [1:0]   count;
    logic         wptr;
    logic         rptr;
    logic         push;
    logic         pop;

    assign wr_rdy = (count != 2'd2);
    assign rd_vld = (count != 2'd0);
    assign push   = wr_vld && wr_rdy && !flush;
    assign pop    = rd_vld && rd_rdy && !flush;
    // Stale storage stays hidden behind zeros whenever the FIFO is empty.
    assign rd_dat = rd_vld ? mem[rptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else if (flush) begin
            count <= 2'd0;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_dat;
    end
endmodule

// Immediate generator: decodes the RISC-V immediate selected by in_type and queues it with its tag.
// Latency: out_valid rises one cycle after an instruction is accepted into an empty queue.
// Backpressure: a two-entry queue absorbs stalls; in_ready is driven only from registered state.
module id_imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_type,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } ent_t;

    ent_t        in_ent;
    ent_t        out_ent;
    logic [31:0] v32;
    logic        unused_opcode;

    assign unused_opcode = ^in_instr[6:0];

    // I/S/B/U/J are assembled as 32-bit values and then sign-extended to XLEN.
    always_comb begin
        v32        = 32'd0;
        in_ent.imm = '0;
        in_ent.tag = in_tag;
        in_ent.err = 1'b0;
        case (in_type)
            3'b000: v32 = {{20{in_instr[31]}}, in_instr[31:20]};
            3'b001: v32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            3'b010: v32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            3'b011: v32 = {in_instr[31:12], 12'd0};
            3'b100: v32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            default: v32 = 32'd0;
        endcase
        case (in_type)
            3'b101: in_ent.imm = XLEN'(in_instr[19:15]);
            3'b110: in_ent.imm = (XLEN == 64) ? XLEN'(in_instr[25:20]) : XLEN'(in_instr[24:20]);
            3'b111: in_ent.err = 1'b1;
            default: in_ent.imm = XLEN'($signed(v32));
        endcase
    end

    sync_fifo2 #(
        .W($bits(ent_t))
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .wr_vld (in_valid),
        .wr_rdy (in_ready),
        .wr_dat (in_ent),
        .rd_vld (out_valid),
        .rd_rdy (out_ready),
        .rd_dat (out_ent)
    );

    assign out_imm = out_ent.imm;
    assign out_tag = out_ent.tag;
    assign out_err = out_ent.err;
endmodule

// File: tb/tb_id_imm_gen_pipe.sv
// Directed bench for id_imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_id_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic [2:0]  in_type = 3'd0;
    logic [31:0] in_tag = 32'd0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_imm, out_tag;
    logic        in_ready64, out_valid64, out_err64;
    logic [63:0] out_imm64;
    logic [31:0] out_tag64;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    id_imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_tag(out_tag), .out_err(out_err)
    );

    id_imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_type(in_type), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction for a single edge, then withdraws it.
    task automatic push(input logic [2:0] t, input logic [31:0] instr, input logic [31:0] tg);
        in_valid = 1'b1;
        in_type  = t;
        in_instr = instr;
        in_tag   = tg;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_imm",   64'(out_imm),   64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_out_err",   64'(out_err),   64'd0);
        #10 rst_n = 1'b1;
        step();

        // Back-to-back decodes with out_ready high: each cycle pops the previous entry and pushes the next.
        out_ready = 1'b1;
        push(3'b000, 32'hFFF00093, 32'h10);
        chk("I_valid", 64'(out_valid), 64'd1);
        chk("I_imm",   64'(out_imm),   64'hFFFF_FFFF);
        chk("I_imm64", out_imm64,      64'hFFFF_FFFF_FFFF_FFFF);
        chk("I_err",   64'(out_err),   64'd0);
        chk("I_tag",   64'(out_tag),   64'h10);
        push(3'b010, 32'hFE000EE3, 32'h11);
        chk("B_imm",   64'(out_imm),   64'hFFFF_FFFC);
        chk("B_tag",   64'(out_tag),   64'h11);
        push(3'b011, 32'h123450B7, 32'h12);
        chk("U_imm",   64'(out_imm),   64'h1234_5000);
        chk("U_imm64", out_imm64,      64'h1234_5000);
        push(3'b011, 32'h800000B7, 32'h13);
        chk("U_neg_imm",   64'(out_imm), 64'h8000_0000);
        chk("U_neg_imm64", out_imm64,    64'hFFFF_FFFF_8000_0000);
        push(3'b110, 32'h03F01013, 32'h14);
        chk("SH_imm",   64'(out_imm), 64'h1F);
        chk("SH_imm64", out_imm64,    64'h3F);
        push(3'b001, 32'hFE112E23, 32'h15);
        chk("S_imm",   64'(out_imm), 64'hFFFF_FFFC);
        push(3'b100, 32'hFFDFF0EF, 32'h16);
        chk("J_imm64", out_imm64,    64'hFFFF_FFFF_FFFF_FFFC);
        chk("J_valid", 64'(out_valid), 64'd1);
        step();
        chk("drain_valid", 64'(out_valid), 64'd0);
        chk("drain_imm",   64'(out_imm),   64'd0);

        // Fill to two under a stall, then release.
        out_ready = 1'b0;
        push(3'b000, 32'h00500093, 32'd1);
        chk("fill1_in_ready", 64'(in_ready), 64'd1);
        push(3'b000, 32'h00700093, 32'd2);
        chk("fill2_in_ready", 64'(in_ready), 64'd0);
        chk("fill2_head_tag", 64'(out_tag),  64'd1);
        push(3'b000, 32'h00900093, 32'd3);
        chk("full_in_ready",  64'(in_ready), 64'd0);
        chk("stall_tag",      64'(out_tag),  64'd1);
        chk("stall_imm",      64'(out_imm),  64'd5);
        // At count=2 with out_ready high, only the pop happens.
        out_ready = 1'b1;
        push(3'b000, 32'h00900093, 32'd3);
        chk("pop1_tag",      64'(out_tag),   64'd2);
        chk("pop1_imm",      64'(out_imm),   64'd7);
        chk("pop1_in_ready", 64'(in_ready),  64'd1);
        step();
        chk("pop2_valid",    64'(out_valid), 64'd0);

        // Flush while full, with a push offered in the same cycle.
        out_ready = 1'b0;
        push(3'b000, 32'h00100093, 32'h21);
        push(3'b000, 32'h00200093, 32'h22);
        chk("pre_flush_in_ready", 64'(in_ready), 64'd0);
        flush = 1'b1;
        out_ready = 1'b1;
        push(3'b000, 32'h00300093, 32'h23);
        flush = 1'b0;
        chk("flush_valid",    64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready),  64'd1);
        step();
        chk("flush_no_emit",  64'(out_valid), 64'd0);
        push(3'b111, 32'hFFFFFFFF, 32'h24);
        chk("bad_valid", 64'(out_valid), 64'd1);
        chk("bad_imm",   64'(out_imm),   64'd0);
        chk("bad_err",   64'(out_err),   64'd1);
        chk("bad_err64", 64'(out_err64), 64'd1);
        step();

        // Asynchronous reset with one entry in flight.
        out_ready = 1'b0;
        push(3'b000, 32'h00100093, 32'h31);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",    64'(out_valid), 64'd0);
        chk("arst_in_ready", 64'(in_ready),  64'd1);
        chk("arst_imm",      64'(out_imm),   64'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        push(3'b101, 32'h000FD073, 32'h32);
        chk("Z_valid", 64'(out_valid), 64'd1);
        chk("Z_imm",   64'(out_imm),   64'h1F);
        chk("Z_tag",   64'(out_tag),   64'h32);
        step();
        chk("Z_drain", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/id_imm_gen_pipe.md
ID_IMM_GEN_PIPE -- requirements
Module: id_imm_gen_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning immediate output width; legal values 32 and 64.
REQ-002 SHALL have parameter TAG_W, default 32, meaning width of the sideband tag carried alongside each instruction (e.g. PC).
REQ-003 SHALL have clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have in_valid  input  1, in_ready  output  1, forming the upstream handshake.
REQ-007 SHALL have in_instr  input  32  raw instruction word; in_type  input  3  immediate type; in_tag  input  TAG_W  sideband.
REQ-008 SHALL have out_valid  output  1, out_ready  input  1, forming the downstream handshake.
REQ-009 SHALL have out_imm  output  XLEN  immediate; out_tag  output  TAG_W; out_err  output  1  unsupported-type flag.

Function
REQ-010 SHALL encode in_type as I=000, S=001, B=010, U=011, J=100, Z=101 (CSR zimm), SH=110 (shift amount), 111=unsupported.
REQ-011 SHALL build I/S/B/J immediates per RV base ISA, sign-extended from instr[31] to XLEN.
REQ-012 SHALL build U as {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN when XLEN=64.
REQ-013 SHALL build Z as zero-extended instr[19:15].
REQ-014 SHALL build SH as zero-extended instr[24:20] for XLEN=32 and instr[25:20] for XLEN=64.
REQ-015 SHALL output out_imm=0 and out_err=1 for type 111; out_err=0 for all other types.
REQ-016 SHALL accept an entry when in_valid && in_ready and pop one when out_valid && out_ready.
REQ-017 SHALL store {imm, tag, err} in a 2-entry FIFO; latency from accept to out_valid is exactly 1 cycle when empty.
REQ-018 SHALL keep out_imm/out_tag/out_err stable while out_valid && !out_ready.
REQ-019 SHALL drive in_ready = (count != 2), from registered state only (no combinational path from out_ready).
REQ-020 SHALL deliver entries in acceptance order; simultaneous push and pop at count=1 leaves count=1.
REQ-021 SHALL, at count=2 with out_ready=1, pop only (in_ready=0 that cycle); count becomes 1.
REQ-022 SHALL, on flush=1, set count=0 next cycle, discard any push and pop in that cycle, and ignore out_ready.
REQ-023 SHALL wrap FIFO read/write pointers modulo 2.
REQ-024 SHALL drive out_valid = (count != 0).

Reset
REQ-025 SHALL, while rst_n=0, force count=0, pointers=0, out_valid=0, in_ready=1 asynchronously.
REQ-026 SHALL drive out_imm=0, out_tag=0, out_err=0 while out_valid=0 after reset.
REQ-027 SHALL lose any in-flight entry on reset mid-operation; first post-reset accept behaves as from empty.

Verification
REQ-028 XLEN=32: type I, instr 0xFFF00093, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_err=0.
REQ-029 XLEN=32: type B, instr 0xFE000EE3 -> out_imm=0xFFFFFFFC; type U, instr 0x123450B7 -> 0x12345000.
REQ-030 XLEN=64: type U, instr 0x800000B7 -> out_imm=0xFFFFFFFF80000000; type SH, instr 0x03F01013 -> 0x3F.
REQ-031 out_ready=0, push tags 1,2 -> in_ready=0 after second push; third in_valid ignored; release out_ready -> tags 1 then 2, in order, values unchanged.
REQ-032 count=2 then flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry emitted; type 111 push afterwards -> out_imm=0, out_err=1.
REQ-033 count=1, rst_n pulsed low mid-cycle -> out_valid=0, in_ready=1 immediately; subsequent type Z push of instr 0x000FD073 -> out_imm=0x1F.
